seq_chunk_adder: RTL and testbench

Multi-cycle, parametrised add/subtract unit. Processes a WIDTH-bit operation CHUNK bits per cycle through a CHUNK-bit ripple chain, with the carry held in a register between chunks. It is a generalised successor to the fixed 4-bit ripple adder. It serves as an area-lean ALU/address adder option for the RV32IM core, with a valid/ready handshake on input and output.

---
 rtl/seq_add_pkg.sv | 15 +
 rtl/rca_n.sv | 29 ++
 rtl/seq_chunk_adder.sv | 122 ++++++++++++
 tb/tb_seq_chunk_adder.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_add_pkg.sv
// rtl/seq_add_pkg.sv - shared types and configuration check for the chunked adder
package seq_add_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // A legal configuration splits the operand into whole, non-empty chunks.
    function automatic bit chunk_cfg_ok(input int width, input int chunk);
        return (chunk >= 1) && (chunk <= width) && ((width % chunk) == 0);
    endfunction

endpackage

// File: rtl/rca_n.sv
// rtl/rca_n.sv - N-bit ripple-carry chunk adder exposing the carry into its MSB
module rca_n #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    // Ripple the carry bit by bit; a local variable keeps the chain acyclic.
    always_comb begin
        logic carry;
        carry    = cin;
        c_msb_in = cin;
        sum      = '0;
        for (int i = 0; i < N; i++) begin
            if (i == N - 1) begin
                c_msb_in = carry;
            end
            sum[i] = a[i] ^ b[i] ^ carry;
            carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
        end
        cout = carry;
    end

endmodule

// File: rtl/seq_chunk_adder.sv
// rtl/seq_chunk_adder.sv - multi-cycle add/subtract processing CHUNK bits per cycle
module seq_chunk_adder
    import seq_add_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    generate
        if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_err
            $error("seq_chunk_adder: WIDTH must be a positive multiple of CHUNK");
        end
    endgenerate

    state_t           state;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             carry;
    logic [IDXW-1:0]  idx;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_sum;
    logic             chunk_cout;
    logic             chunk_c_msb;
    logic [WIDTH-1:0] sum_next;

    assign in_ready = (state == ST_IDLE);

    // Select the operand slice for the current chunk.
    always_comb begin
        chunk_a = a_q[idx*CHUNK +: CHUNK];
        chunk_b = b_q[idx*CHUNK +: CHUNK];
    end

    rca_n #(
        .N(CHUNK)
    ) u_rca (
        .a        (chunk_a),
        .b        (chunk_b),
        .cin      (carry),
        .sum      (chunk_sum),
        .cout     (chunk_cout),
        .c_msb_in (chunk_c_msb)
    );

    // Assembled result after this cycle's chunk, so zero sees the final value.
    always_comb begin
        sum_next                     = sum;
        sum_next[idx*CHUNK +: CHUNK] = chunk_sum;
    end

    // Control FSM, chunk index, carry chain register and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            a_q       <= '0;
            b_q       <= '0;
            carry     <= 1'b0;
            idx       <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            zero      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        a_q   <= a;
                        b_q   <= sub ? ~b : b;
                        carry <= sub;
                        idx   <= '0;
                        sum   <= '0;
                        state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    sum   <= sum_next;
                    carry <= chunk_cout;
                    if (idx == LAST_IDX) begin
                        cout      <= chunk_cout;
                        ovf       <= chunk_cout ^ chunk_c_msb;
                        zero      <= (sum_next == '0);
                        out_valid <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_chunk_adder.sv
// tb/tb_seq_chunk_adder.sv - scoreboard bench for seq_chunk_adder over several chunk sizes
module tb_seq_chunk_adder;

    typedef struct {
        logic [31:0] sum;
        logic        cout;
        logic        ovf;
        logic        zero;
        int          accept;
        int          stall;
    } exp_t;

    logic clk;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s inst%0d actual=%h required=%h", name, inst, act, req);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] s, input logic c, input logic o, input logic z, input int stall);
        exp_t e;
        e.sum = s; e.cout = c; e.ovf = o; e.zero = z; e.accept = 0; e.stall = stall;
        return e;
    endfunction

    function automatic exp_t model(input logic [31:0] x, input logic [31:0] y, input logic s, input int stall);
        logic [32:0] f;
        logic [31:0] yy;
        exp_t e;
        yy = s ? ~y : y;
        f = {1'b0, x} + {1'b0, yy} + {32'd0, s};
        e.sum  = f[31:0];
        e.cout = f[32];
        if (s) e.ovf = (x[31] != y[31]) && (e.sum[31] != x[31]);
        else   e.ovf = (x[31] == y[31]) && (e.sum[31] != x[31]);
        e.zero   = (e.sum == 32'd0);
        e.accept = 0;
        e.stall  = stall;
        return e;
    endfunction

    genvar g;
    for (g = 0; g < 4; g++) begin : g_inst
        localparam int CH = (g == 0) ? 8 : (g == 1) ? 1 : (g == 2) ? 4 : 32;
        localparam int NC = 32 / CH;

        logic        rst_n, in_valid, in_ready, sub, out_valid, out_ready, cout, ovf, zero;
        logic [31:0] a, b, sum;
        exp_t        sb[$];
        int          hs_cycle = 0;
        int          last_accept = 0;
        bit          done_f = 1'b0;

        seq_chunk_adder #(.WIDTH(32), .CHUNK(CH)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .in_valid  (in_valid),
            .in_ready  (in_ready),
            .a         (a),
            .b         (b),
            .sub       (sub),
            .out_valid (out_valid),
            .out_ready (out_ready),
            .sum       (sum),
            .cout      (cout),
            .ovf       (ovf),
            .zero      (zero)
        );

        // Present one operation at a negedge and return at the negedge after it is taken.
        task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic isub,
                             input exp_t e, input bit expect_out, output int waited);
            int   t;
            exp_t q;
            t = 0;
            a = ia; b = ib; sub = isub; in_valid = 1'b1;
            while (!in_ready && t < 400) begin
                @(negedge clk);
                t++;
            end
            if (!in_ready) chk("accept_timeout", g, 32'd0, 32'd1);
            q = e;
            q.accept = cyc + 1;
            last_accept = q.accept;
            if (expect_out) sb.push_back(q);
            @(posedge clk);
            @(negedge clk);
            in_valid = 1'b0;
            a = ~ia; b = ib ^ 32'h5a5a_0f0f; sub = ~isub;
            waited = t;
        endtask

        task automatic drain();
            int t;
            t = 0;
            while (sb.size() != 0 && t < 500) begin
                @(negedge clk);
                t++;
            end
            if (sb.size() != 0) chk("drain_timeout", g, 32'(sb.size()), 32'd0);
            repeat (2) @(negedge clk);
            done_f = 1'b1;
        endtask

        // Monitor: pop on each new result, check hold during stall, drive out_ready.
        initial begin
            bit   in_res;
            int   stall_left;
            exp_t cur;
            in_res = 1'b0;
            stall_left = 0;
            cur = mk(32'd0, 1'b0, 1'b0, 1'b0, 0);
            out_ready = 1'b1;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    in_res = 1'b0;
                    out_ready = 1'b1;
                    continue;
                end
                if (out_valid && !in_res) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_out_valid", g, 32'd1, 32'd0);
                        cur = mk(sum, cout, ovf, zero, 0);
                    end else begin
                        cur = sb.pop_front();
                        chk("sum", g, sum, cur.sum);
                        chk("cout", g, {31'd0, cout}, {31'd0, cur.cout});
                        chk("ovf", g, {31'd0, ovf}, {31'd0, cur.ovf});
                        chk("zero", g, {31'd0, zero}, {31'd0, cur.zero});
                        chk("latency", g, 32'(cyc), 32'(cur.accept + NC));
                    end
                    in_res = 1'b1;
                    stall_left = cur.stall;
                end else if (out_valid && in_res) begin
                    chk("hold_sum", g, sum, cur.sum);
                    chk("hold_flags", g, {29'd0, cout, ovf, zero}, {29'd0, cur.cout, cur.ovf, cur.zero});
                    if (stall_left > 0) stall_left--;
                end else if (!out_valid && in_res) begin
                    chk("valid_dropped", g, 32'd0, 32'd1);
                    in_res = 1'b0;
                end
                if (out_valid && in_res) begin
                    out_ready = (stall_left == 0);
                    if (stall_left == 0) begin
                        hs_cycle = cyc + 1;
                        in_res = 1'b0;
                    end
                end else begin
                    out_ready = 1'b1;
                end
            end
        end

        if (g == 0) begin : g_dir
            // Directed vectors with hand-computed results, backpressure and mid-run reset.
            initial begin
                int w;
                rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
                repeat (2) @(negedge clk);
                chk("rst_sum", g, sum, 32'd0);
                chk("rst_flags", g, {29'd0, cout, ovf, zero}, 32'd0);
                chk("rst_out_valid", g, {31'd0, out_valid}, 32'd0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("rst_in_ready", g, {31'd0, in_ready}, 32'd1);

                issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 0), 1'b1, w);
                issue(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, mk(32'h8000_0000, 1'b0, 1'b1, 1'b0, 0), 1'b1, w);
                issue(32'h0000_0005, 32'h0000_0007, 1'b1, mk(32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 0), 1'b1, w);
                issue(32'h8000_0000, 32'h0000_0001, 1'b1, mk(32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0, 0), 1'b1, w);
                issue(32'h0000_1234, 32'h0000_1234, 1'b1, mk(32'h0000_0000, 1'b1, 1'b0, 1'b1, 0), 1'b1, w);

                issue(32'h1111_1111, 32'h2222_2222, 1'b0, mk(32'h3333_3333, 1'b0, 1'b0, 1'b0, 3), 1'b1, w);
                issue(32'hA5A5_A5A5, 32'h5A5A_5A5A, 1'b1, mk(32'h4B4B_4B4B, 1'b1, 1'b1, 1'b0, 0), 1'b1, w);
                chk("busy_wait_cycles", g, 32'(w), 32'd8);
                chk("accept_after_handshake", g, 32'(last_accept), 32'(hs_cycle + 1));

                issue(32'hDEAD_0000, 32'h0000_BEEF, 1'b0, mk(32'd0, 1'b0, 1'b0, 1'b0, 0), 1'b0, w);
                repeat (2) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                chk("midrst_sum", g, sum, 32'd0);
                chk("midrst_flags", g, {29'd0, cout, ovf, zero}, 32'd0);
                chk("midrst_out_valid", g, {31'd0, out_valid}, 32'd0);
                rst_n = 1'b1;
                @(negedge clk);
                chk("midrst_in_ready", g, {31'd0, in_ready}, 32'd1);
                repeat (6) @(negedge clk);
                chk("midrst_no_valid", g, {31'd0, out_valid}, 32'd0);
                issue(32'd3, 32'd4, 1'b0, mk(32'd7, 1'b0, 1'b0, 1'b0, 0), 1'b1, w);
                drain();
            end
        end else begin : g_rnd
            // Random add/sub against the reference model with random backpressure.
            initial begin
                int          w;
                logic [31:0] ra, rb;
                logic        rs;
                rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0;
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                for (int i = 0; i < 1000; i++) begin
                    ra = $urandom;
                    rb = ($urandom_range(0, 7) == 0) ? ra : $urandom;
                    rs = 1'($urandom_range(0, 1));
                    issue(ra, rb, rs, model(ra, rb, rs, $urandom_range(0, 2)), 1'b1, w);
                end
                drain();
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(g_inst[0].done_f && g_inst[1].done_f && g_inst[2].done_f && g_inst[3].done_f) && t < 60000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 60000) chk("global_timeout", 0, 32'(t), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
